// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART RX frame checker: FSM state encoding plus parity/stop selectors.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_rx_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP1  = 3'd3;
    localparam logic [2:0] ST_STOP2  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP1  = ST_STOP1,
        S_STOP2  = ST_STOP2
    } state_t;

    // par_typ values
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // stp_num values
    localparam logic STP_ONE  = 1'b0;
    localparam logic STP_TWO  = 1'b1;

endpackage

// File: rtl/uart_rx_err_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: cnt reflects an inc one clock later.
// Backpressure: none; inc is sampled every cycle.
//
// Ports: clk, rst (async active-high), inc (count enable), cnt (current count).
module uart_rx_err_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: assembles DATA_WIDTH LSB-first data bits, checks optional parity and 1/2 stop bits.
// Latency: data_valid pulses the cycle after the final stop-bit strobe.
// Backpressure: none; one bit consumed per bit_valid strobe, frame_start always wins (aborts a frame in progress).
//
// Ports: clk, rst (async active-high); frame_start, bit_valid, sampled_bit from the data sampler;
//        par_en / par_typ / stp_num frame config (latched at frame_start);
//        rx_data, data_valid, par_err, stp_err, busy toward the system synchroniser.
// Optional: define UART_RX_ERR_CNT_EN to add saturating par_err_cnt / stp_err_cnt outputs.
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stp_num,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
`endif
);

    import uart_rx_pkg::*;

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CNT_WIDTH < 1) begin : g_bad_param
        $error("uart_rx_frame_check: parameter out of range");
    end

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  bit_cnt;
    logic           acc;
    logic           par_en_q;
    logic           par_typ_q;
    logic           stp_num_q;
    logic           par_err_d;
    logic           stp_err_d;
    logic           frame_end;

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the error flags as they will stand after this edge.
    // frame_start takes priority over any bit_valid in the same cycle.
    always_comb begin
        state_d   = state_q;
        par_err_d = par_err;
        stp_err_d = stp_err;
        frame_end = 1'b0;
        if (frame_start) begin
            state_d   = S_DATA;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
        end else if (bit_valid) begin
            case (state_q)
                S_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    par_err_d = sampled_bit ^ acc ^ (par_typ_q == PAR_ODD);
                    state_d   = S_STOP1;
                end
                S_STOP1: begin
                    stp_err_d = ~sampled_bit;
                    if (stp_num_q == STP_TWO) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d   = S_IDLE;
                        frame_end = 1'b1;
                    end
                end
                S_STOP2: begin
                    // A bad first stop bit stays flagged regardless of the second.
                    stp_err_d = stp_err | ~sampled_bit;
                    state_d   = S_IDLE;
                    frame_end = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            bit_cnt    <= '0;
            acc        <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stp_num_q  <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            par_err    <= par_err_d;
            stp_err    <= stp_err_d;
            data_valid <= frame_end & ~par_err_d & ~stp_err_d;
            if (frame_start) begin
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                stp_num_q <= stp_num;
                acc       <= 1'b0;
                bit_cnt   <= '0;
            end else if (bit_valid && (state_q == S_DATA)) begin
                rx_data[bit_cnt] <= sampled_bit;
                acc              <= acc ^ sampled_bit;
                bit_cnt          <= bit_cnt + CW'(1);
            end
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // Increments only on a completed frame; an abort never reaches frame_end.
    logic par_inc;
    logic stp_inc;

    assign par_inc = frame_end & par_err_d;
    assign stp_inc = frame_end & stp_err_d;

    uart_rx_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk (clk),
        .rst (rst),
        .inc (par_inc),
        .cnt (par_err_cnt)
    );

    uart_rx_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stp_inc),
        .cnt (stp_err_cnt)
    );
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check (DATA_WIDTH=8, CNT_WIDTH=2).
// Inputs are driven 1 time unit after the rising edge; outputs are checked there or at later points away from the edge.
// Counter checks are compiled in only when UART_RX_ERR_CNT_EN is defined.
module tb_uart_rx_frame_check;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sampled_bit = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stp_num = 1'b0;
    logic [7:0] rx_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [1:0] par_err_cnt;
    logic [1:0] stp_err_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int dv_pulses = 0;

    uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bit_valid   (bit_valid),
        .sampled_bit (sampled_bit),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .stp_num     (stp_num),
        .rx_data     (rx_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid === 1'b1) dv_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Config is scrambled right after the strobe; the DUT must have latched it.
    task automatic start_frame(input logic pe, input logic pt, input logic sn);
        par_en = pe;
        par_typ = pt;
        stp_num = sn;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        par_en = ~pe;
        par_typ = ~pt;
        stp_num = ~sn;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit_valid = 1'b1;
        sampled_bit = b;
        tick(1);
        bit_valid = 1'b0;
        sampled_bit = ~b;
        tick(gap);
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i], i % 2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        tests++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin fails++; $display("FAIL reset_errs got %b%b want 00", par_err, stp_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef UART_RX_ERR_CNT_EN
        tests++; if (par_err_cnt !== 2'd0 || stp_err_cnt !== 2'd0) begin fails++; $display("FAIL reset_cnts got %0d/%0d want 0/0", par_err_cnt, stp_err_cnt); end
`endif
        rst = 1'b0;
        tick(2);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_clean_frame();
        int d0;
        do_reset();
        send_bit(1'b1, 1);   // ignored in IDLE
        tests++; if (rx_data !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL idle_ignore got rx=%h busy=%b want 00/0", rx_data, busy); end
        start_frame(1'b0, 1'b0, 1'b0);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clean_busy got %b want 1", busy); end
        send_data(8'hA5);
        tests++; if (rx_data !== 8'hA5 || data_valid !== 1'b0) begin fails++; $display("FAIL clean_pre_stop got rx=%h dv=%b want a5/0", rx_data, data_valid); end
        d0 = dv_pulses;
        send_bit(1'b1, 0);
        tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL clean_dv got %b want 1", data_valid); end
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL clean_rx_data got %h want a5", rx_data); end
        tests++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin fails++; $display("FAIL clean_errs got %b%b want 00", par_err, stp_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL clean_busy_end got %b want 0", busy); end
        tick(1);
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL clean_dv_width got %b want 0", data_valid); end
        tick(1);
        tests++; if (dv_pulses - d0 !== 1) begin fails++; $display("FAIL clean_dv_count got %0d want 1", dv_pulses - d0); end
    endtask

    task automatic test_parity();
        int d0;
        do_reset();
        d0 = dv_pulses;
        // 0x07 has three ones: even parity bit should be 1, a 0 is an error
        start_frame(1'b1, 1'b0, 1'b0);
        send_data(8'h07);
        send_bit(1'b0, 1);
        send_bit(1'b1, 2);
        tests++; if (par_err !== 1'b1 || stp_err !== 1'b0) begin fails++; $display("FAIL par_even_errs got %b%b want 10", par_err, stp_err); end
        tests++; if (dv_pulses - d0 !== 0) begin fails++; $display("FAIL par_even_dv got %0d want 0", dv_pulses - d0); end
        tests++; if (rx_data !== 8'h07) begin fails++; $display("FAIL par_even_rx got %h want 07", rx_data); end
`ifdef UART_RX_ERR_CNT_EN
        tests++; if (par_err_cnt !== 2'd1 || stp_err_cnt !== 2'd0) begin fails++; $display("FAIL par_cnt got %0d/%0d want 1/0", par_err_cnt, stp_err_cnt); end
`endif
        // odd parity, same data: parity bit 0 is correct
        start_frame(1'b1, 1'b1, 1'b0);
        tick(1);
        tests++; if (par_err !== 1'b0) begin fails++; $display("FAIL par_clear got %b want 0", par_err); end
        send_data(8'h07);
        send_bit(1'b0, 0);
        tests++; if (busy !== 1'b1 || data_valid !== 1'b0) begin fails++; $display("FAIL par_odd_mid got busy=%b dv=%b want 1/0", busy, data_valid); end
        send_bit(1'b1, 0);
        tests++; if (data_valid !== 1'b1 || par_err !== 1'b0) begin fails++; $display("FAIL par_odd_ok got dv=%b perr=%b want 1/0", data_valid, par_err); end
`ifdef UART_RX_ERR_CNT_EN
        tests++; if (par_err_cnt !== 2'd1) begin fails++; $display("FAIL par_cnt_hold got %0d want 1", par_err_cnt); end
`endif
    endtask

    task automatic test_two_stop();
        int d0;
        do_reset();
        d0 = dv_pulses;
        start_frame(1'b0, 1'b0, 1'b1);
        send_data(8'h5A);
        send_bit(1'b1, 0);
        send_bit(1'b0, 2);
        tests++; if (stp_err !== 1'b1 || par_err !== 1'b0) begin fails++; $display("FAIL stop_10 got %b%b want 01", par_err, stp_err); end
        start_frame(1'b0, 1'b0, 1'b1);
        tick(1);
        tests++; if (stp_err !== 1'b0) begin fails++; $display("FAIL stop_clear got %b want 0", stp_err); end
        send_data(8'h5A);
        send_bit(1'b0, 1);
        tests++; if (stp_err !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL stop_first_bad got err=%b busy=%b want 1/1", stp_err, busy); end
        send_bit(1'b1, 2);
        tests++; if (stp_err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL stop_01 got err=%b busy=%b want 1/0", stp_err, busy); end
        tests++; if (dv_pulses - d0 !== 0) begin fails++; $display("FAIL stop_bad_dv got %0d want 0", dv_pulses - d0); end
        start_frame(1'b0, 1'b0, 1'b1);
        send_data(8'hFF);
        send_bit(1'b1, 0);
        tests++; if (data_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL stop_11_mid got dv=%b busy=%b want 0/1", data_valid, busy); end
        send_bit(1'b1, 0);
        tests++; if (data_valid !== 1'b1 || rx_data !== 8'hFF) begin fails++; $display("FAIL stop_11 got dv=%b rx=%h want 1/ff", data_valid, rx_data); end
`ifdef UART_RX_ERR_CNT_EN
        tests++; if (stp_err_cnt !== 2'd2 || par_err_cnt !== 2'd0) begin fails++; $display("FAIL stop_cnt got %0d/%0d want 0/2", par_err_cnt, stp_err_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        int d0;
`ifdef UART_RX_ERR_CNT_EN
        logic [1:0] pc0;
        logic [1:0] sc0;
        pc0 = par_err_cnt;
        sc0 = stp_err_cnt;
`endif
        tick(2);
        d0 = dv_pulses;
        start_frame(1'b0, 1'b0, 1'b0);
        send_data(8'hFF >> 4);       // only the low nibble matters: 4 ones
        // (the above sends 8 bits; restart the frame partway by aborting a fresh one)
        start_frame(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 1);
        send_bit(1'b1, 0);
        // abort: frame_start with a simultaneous bit_valid that must be ignored
        bit_valid = 1'b1;
        sampled_bit = 1'b1;
        start_frame(1'b0, 1'b0, 1'b0);
        bit_valid = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy got %b want 1", busy); end
        send_data(8'h3C);
        send_bit(1'b1, 0);
        tests++; if (data_valid !== 1'b1 || rx_data !== 8'h3C) begin fails++; $display("FAIL abort_new got dv=%b rx=%h want 1/3c", data_valid, rx_data); end
        // new frame starts on the data_valid cycle
        start_frame(1'b0, 1'b0, 1'b0);
        send_data(8'h81);
        send_bit(1'b1, 0);
        tests++; if (data_valid !== 1'b1 || rx_data !== 8'h81) begin fails++; $display("FAIL b2b got dv=%b rx=%h want 1/81", data_valid, rx_data); end
        tick(2);
        // first 8-bit frame was aborted mid-stop: never completes
        tests++; if (dv_pulses - d0 !== 2) begin fails++; $display("FAIL abort_dv_count got %0d want 2", dv_pulses - d0); end
`ifdef UART_RX_ERR_CNT_EN
        tests++; if (par_err_cnt !== pc0 || stp_err_cnt !== sc0) begin fails++; $display("FAIL abort_cnts got %0d/%0d want %0d/%0d", par_err_cnt, stp_err_cnt, pc0, sc0); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        start_frame(1'b1, 1'b1, 1'b0);
        send_data(8'hC3);
        tests++; if (busy !== 1'b1 || rx_data !== 8'hC3) begin fails++; $display("FAIL mid_pre got busy=%b rx=%h want 1/c3", busy, rx_data); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (rx_data !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL mid_rst got rx=%h busy=%b want 00/0", rx_data, busy); end
        tests++; if (par_err !== 1'b0 || stp_err !== 1'b0 || data_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_flags got %b%b%b want 000", par_err, stp_err, data_valid); end
`ifdef UART_RX_ERR_CNT_EN
        tests++; if (stp_err_cnt !== 2'd0) begin fails++; $display("FAIL mid_rst_cnt got %0d want 0", stp_err_cnt); end
`endif
        tick(1);
        rst = 1'b0;
        send_bit(1'b0, 1);
        tests++; if (busy !== 1'b0 || par_err !== 1'b0) begin fails++; $display("FAIL post_rst got busy=%b perr=%b want 0/0", busy, par_err); end
    endtask

`ifdef UART_RX_ERR_CNT_EN
    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            start_frame(1'b0, 1'b0, 1'b0);
            send_data(8'(k * 17));
            send_bit(1'b0, 1);
            exp_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
            tests++; if (stp_err_cnt !== exp_cnt) begin fails++; $display("FAIL sat_stp_cnt frame %0d got %0d want %0d", k, stp_err_cnt, exp_cnt); end
        end
        tests++; if (par_err_cnt !== 2'd0) begin fails++; $display("FAIL sat_par_cnt got %0d want 0", par_err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_frame();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_ERR_CNT_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
